// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch funct3 codes and datapath defaults
// used by the fetch front end and its bus interface.
package cpu_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: program ROM read port plus the valid/ready
// instruction handshake toward decode.
interface fetch_unit_if #(
  parameter int XLEN   = cpu_pkg::DEF_XLEN,
  parameter int ADDR_W = 14
);

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    output imem_en, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_en, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer between the ROM response and decode. When empty the
// head output keeps showing the last value that was presented.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [W-1:0]  last_q;

  assign head = (count != '0) ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= head;
    end else begin
      last_q <= head;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, ROM request, response FIFO and redirect.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              ADDR_W   = 14,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upg_done,
  fetch_unit_if.master    bus,
  input  logic            br_valid,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  output logic            fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH);

  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    inflight_pc_q;
  logic               inflight_q;
  logic               fetch_err_q;
  logic [CW:0]        count;
  logic [31+XLEN:0]   head;
  logic               head_valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic               credit_ok;
  logic               br_cond;
  logic               redirect;
  logic [XLEN-1:0]    target;
  logic [XLEN-1:0]    redirect_pc;

  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      BR_BEQ:  br_cond = (br_rs1 == br_rs2);
      BR_BNE:  br_cond = (br_rs1 != br_rs2);
      BR_BLT:  br_cond = ($signed(br_rs1) <  $signed(br_rs2));
      BR_BGE:  br_cond = ($signed(br_rs1) >= $signed(br_rs2));
      BR_BLTU: br_cond = (br_rs1 <  br_rs2);
      BR_BGEU: br_cond = (br_rs1 >= br_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  assign redirect    = jmp_valid | (br_valid & br_cond);
  assign target      = jmp_valid ? {jmp_target[XLEN-1:1], 1'b0} : (br_pc + br_imm);
  assign redirect_pc = target[1] ? {target[XLEN-1:2], 2'b00} : target;

  assign head_valid = (count != '0);
  assign pop        = head_valid & bus.inst_ready;

  // Credits count buffered entries plus the response still in flight, so a
  // full FIFO can never be overrun by an outstanding ROM read.
  assign credit_ok = (int'(count) + int'(inflight_q) - int'(pop)) < DEPTH;
  assign issue     = rst & upg_done & ~redirect & credit_ok;

  // A response arriving in the redirect cycle belongs to the old path.
  assign push = inflight_q & ~redirect;

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = pc_q[ADDR_W+1:2];
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head[31+XLEN:XLEN];
  assign bus.inst_pc    = head[XLEN-1:0];
  assign fetch_err      = fetch_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect) begin
        pc_q <= redirect_pc;
        if (target[1]) begin
          fetch_err_q <= 1'b1;
        end
      end else if (issue) begin
        pc_q <= pc_q + {{(XLEN-3){1'b0}}, 3'd4};
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.imem_rdata, inflight_pc_q}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flush   <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, a monitor
// checks every decode handshake. ROM word k holds value k.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        upg_done;
  logic        br_valid;
  logic [2:0]  br_type;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flush;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  typedef struct packed {
    logic        brv;
    logic [2:0]  bt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        jv;
    logic [31:0] jt;
    logic        taken;
    logic [31:0] tgt;
    logic        err;
  } case_t;

  case_t cases[$];

  fetch_unit_if #(.XLEN(32), .ADDR_W(14)) bus ();

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .upg_done     (upg_done),
    .bus          (bus),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .br_rs1       (br_rs1),
    .br_rs2       (br_rs2),
    .br_pc        (br_pc),
    .br_imm       (br_imm),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .fetch_err    (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flush   (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program ROM, one cycle of read latency.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'(bus.imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pop: got pc %h expected none", bus.inst_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        checkOutput("sb_pc", bus.inst_pc, mon_pc);
        checkOutput("sb_inst", bus.inst, {18'b0, mon_pc[15:2]});
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    upg_done = 1'b1;
    bus.inst_ready = 1'b1;
    br_valid = 1'b0;
    br_type = 3'b000;
    br_rs1 = '0;
    br_rs2 = '0;
    br_pc = '0;
    br_imm = '0;
    jmp_valid = 1'b0;
    jmp_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_en", 32'(bus.imem_en), 32'd0);
    checkOutput("rst_inst", bus.inst, 32'd0);
    checkOutput("rst_pc", bus.inst_pc, 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.inst_valid) && n < 40) begin
      nextCycle();
      n++;
    end
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("idle_en", 32'(bus.imem_en), 32'd0);
    checkOutput("idle_valid", 32'(bus.inst_valid), 32'd0);
  endtask

  // Redirect presented in cycle 6 while the head (pc 0x10) is being popped.
  task automatic applyStimulus(input case_t c);
    doReset();
    if (c.taken) begin
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
      exp_q.push_back(c.tgt);
      exp_q.push_back(c.tgt + 32'd4);
    end else begin
      for (int i = 0; i < 9; i++) exp_q.push_back(32'(4 * i));
    end
    repeat (6) nextCycle();
    br_valid = c.brv;
    br_type = c.bt;
    br_rs1 = c.rs1;
    br_rs2 = c.rs2;
    br_pc = 32'h10;
    br_imm = c.imm;
    jmp_valid = c.jv;
    jmp_target = c.jt;
    @(negedge clk);
    checkOutput("redir_en", 32'(bus.imem_en), 32'(!c.taken));
    checkOutput("err_before", 32'(fetch_err), 32'd0);
    nextCycle();
    br_valid = 1'b0;
    jmp_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_set", 32'(fetch_err), 32'(c.err));
    nextCycle();
    nextCycle();
    upg_done = 1'b0;
    waitDrain();
    checkOutput("err_hold", 32'(fetch_err), 32'(c.err));
  endtask

  function automatic case_t mk(input logic brv, input logic [2:0] bt, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm, input logic jv,
                               input logic [31:0] jt, input logic taken, input logic [31:0] tgt,
                               input logic err);
    case_t c;
    c.brv = brv; c.bt = bt; c.rs1 = rs1; c.rs2 = rs2; c.imm = imm;
    c.jv = jv; c.jt = jt; c.taken = taken; c.tgt = tgt; c.err = err;
    return c;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Sustained stream: one instruction per cycle from cycle 2.
    doReset();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    nextCycle();
    nextCycle();
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      checkOutput("tput_valid", 32'(bus.inst_valid), 32'd1);
      checkOutput("tput_pc", bus.inst_pc, 32'(4 * (c - 2)));
      nextCycle();
    end
    upg_done = 1'b0;
    waitDrain();

    // Decode stall: head holds, issue stops after two outstanding.
    doReset();
    bus.inst_ready = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    checkOutput("stall_en0", 32'(bus.imem_en), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("stall_en1", 32'(bus.imem_en), 32'd1);
    for (int c = 2; c < 7; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("stall_valid", 32'(bus.inst_valid), 32'd1);
      checkOutput("stall_pc", bus.inst_pc, 32'd0);
      checkOutput("stall_inst", bus.inst, 32'd0);
      checkOutput("stall_en", 32'(bus.imem_en), 32'd0);
    end
    nextCycle();
    bus.inst_ready = 1'b1;
    nextCycle();
    upg_done = 1'b0;
    waitDrain();

    // Redirect table: hand-computed taken flag, target and error flag.
    cases.push_back(mk(1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF8, 0, 0, 1, 32'h08, 0));
    cases.push_back(mk(1, 3'b000, 32'd6, 32'd7, 32'hFFFF_FFF8, 0, 0, 0, 0, 0));
    cases.push_back(mk(1, 3'b001, 32'd7, 32'd7, 32'h40, 0, 0, 0, 0, 0));
    cases.push_back(mk(1, 3'b001, 32'd6, 32'd7, 32'h40, 0, 0, 1, 32'h50, 0));
    cases.push_back(mk(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0));
    cases.push_back(mk(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 0, 0, 1, 32'h08, 0));
    cases.push_back(mk(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 0, 0, 0, 0));
    cases.push_back(mk(1, 3'b101, 32'd5, 32'hFFFF_FFFF, 32'h10, 0, 0, 1, 32'h20, 0));
    cases.push_back(mk(1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 1, 32'h30, 0));
    cases.push_back(mk(1, 3'b010, 32'd7, 32'd7, 32'hFFFF_FFF8, 0, 0, 0, 0, 0));
    cases.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h103, 1, 32'h100, 1));
    cases.push_back(mk(1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF8, 1, 32'h201, 1, 32'h200, 0));
    cases.push_back(mk(1, 3'b000, 32'd3, 32'd3, 32'h72, 0, 0, 1, 32'h80, 1));
    cases.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0));
    foreach (cases[i]) applyStimulus(cases[i]);

    // Programmer not finished: nothing fetched until upg_done rises.
    doReset();
    upg_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("upg_en", 32'(bus.imem_en), 32'd0);
      checkOutput("upg_valid", 32'(bus.inst_valid), 32'd0);
      nextCycle();
    end
    upg_done = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    checkOutput("upg_first_en", 32'(bus.imem_en), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("upg_lat_valid", 32'(bus.inst_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("upg_first_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("upg_first_pc", bus.inst_pc, 32'h0);
    nextCycle();
    upg_done = 1'b0;
    waitDrain();

    // Reset while fetches are in flight: stale data must never appear.
    doReset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    repeat (4) nextCycle();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("midrst_pc", bus.inst_pc, 32'd0);
    checkOutput("midrst_inst", bus.inst, 32'd0);
    checkOutput("midrst_q", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    repeat (3) nextCycle();
    upg_done = 1'b0;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
